// File: rtl/ctrl_link_slave_param.sv
// Control-link slave: comma-framed requests in, strobe/ack bus transaction out, continuous status/rdata frames back.
// Define CTRL_LINK_CRC_EN to add a CRC-8 byte (poly 0x07) to both request and response frames.
module ctrl_link_slave_param #(
  parameter int ADDR_BYTES   = 2,
  parameter int DATA_BYTES   = 4,
  parameter int BUS_TIMEOUT  = 255,
  parameter int LINK_TIMEOUT = 64
) (
  input  logic                    byte_clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_is_k,
  input  logic                    rx_valid,
  output logic [7:0]              tx_byte,
  output logic                    tx_is_k,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  output logic                    bus_write,
  output logic                    bus_strobe,
  input  logic                    bus_ack,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    link_ok,
  output logic [7:0]              frame_err_cnt
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUS_TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_LIM  = LW'(LINK_TIMEOUT);
  localparam logic [2:0]    ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BYTES - 1);
  localparam logic [7:0]    K_COMMA   = 8'hBC;
`ifdef CTRL_LINK_CRC_EN
  localparam logic [3:0]    TX_LAST   = 4'(DATA_BYTES + 2);
`else
  localparam logic [3:0]    TX_LAST   = 4'(DATA_BYTES + 1);
`endif

  typedef enum logic [2:0] {
    S_HUNT, S_CTRL, S_ADDR, S_DATA, S_WAIT
`ifdef CTRL_LINK_CRC_EN
    , S_CHK
`endif
  } state_t;

`ifdef CTRL_LINK_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    tag_q, tag_d;
  logic          wr_q, wr_d, stb_q, stb_d;
  logic [AW-1:0] addr_buf_q, addr_buf_d;
  logic [DW-1:0] data_buf_q, data_buf_d;
`ifdef CTRL_LINK_CRC_EN
  logic [7:0]    rx_crc_q, rx_crc_d;
`endif
  logic          comma, is_data, commit, err_inc, accept;

  assign comma   = rx_valid && rx_is_k && (rx_byte == K_COMMA);
  assign is_data = rx_valid && !rx_is_k;

  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HUNT;
      cnt_q      <= '0;
      tag_q      <= '0;
      wr_q       <= 1'b0;
      stb_q      <= 1'b0;
      addr_buf_q <= '0;
      data_buf_q <= '0;
`ifdef CTRL_LINK_CRC_EN
      rx_crc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      wr_q       <= wr_d;
      stb_q      <= stb_d;
      addr_buf_q <= addr_buf_d;
      data_buf_q <= data_buf_d;
`ifdef CTRL_LINK_CRC_EN
      rx_crc_q   <= rx_crc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    wr_d       = wr_q;
    stb_d      = stb_q;
    addr_buf_d = addr_buf_q;
    data_buf_d = data_buf_q;
`ifdef CTRL_LINK_CRC_EN
    rx_crc_d   = rx_crc_q;
`endif
    commit     = 1'b0;
    err_inc    = 1'b0;
    if (comma) begin
      // Every comma opens a new frame; only one following a complete frame commits it.
      state_d = S_CTRL;
`ifdef CTRL_LINK_CRC_EN
      rx_crc_d = '0;
`endif
      if (state_q == S_WAIT) commit = 1'b1;
      else if (state_q != S_HUNT) err_inc = 1'b1;
    end else if (state_q != S_HUNT) begin
      if (!is_data) begin
        state_d = S_HUNT;
        err_inc = 1'b1;
      end else begin
        case (state_q)
          S_CTRL: begin
            tag_d   = rx_byte[7:4];
            wr_d    = rx_byte[1];
            stb_d   = rx_byte[0];
            cnt_d   = '0;
            state_d = S_ADDR;
`ifdef CTRL_LINK_CRC_EN
            rx_crc_d = crc8(rx_crc_q, rx_byte);
`endif
          end
          S_ADDR: begin
            addr_buf_d[8*cnt_q +: 8] = rx_byte;
`ifdef CTRL_LINK_CRC_EN
            rx_crc_d = crc8(rx_crc_q, rx_byte);
`endif
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              state_d = S_DATA;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          S_DATA: begin
            data_buf_d[8*cnt_q +: 8] = rx_byte;
`ifdef CTRL_LINK_CRC_EN
            rx_crc_d = crc8(rx_crc_q, rx_byte);
`endif
            if (cnt_q == DATA_LAST) begin
              cnt_d = '0;
`ifdef CTRL_LINK_CRC_EN
              state_d = S_CHK;
`else
              state_d = S_WAIT;
`endif
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
`ifdef CTRL_LINK_CRC_EN
          S_CHK: begin
            if (rx_byte == rx_crc_q) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_HUNT;
              err_inc = 1'b1;
            end
          end
`endif
          default: begin
            state_d = S_HUNT;
            err_inc = 1'b1;
          end
        endcase
      end
    end
  end

  logic [7:0]    err_q;
  logic [3:0]    last_tag_q;
  logic          strobe_q, write_q, ack_q, timeout_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] link_cnt_q;
  logic          link_ok_q;

  // A busy bus drops the request silently; the host retries with the same tag.
  assign accept = commit && stb_q && (tag_q != last_tag_q) && !strobe_q;

  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q   <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last_tag_q <= 4'hF;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_q      <= '0;
    end else if (accept) begin
      strobe_q   <= 1'b1;
      write_q    <= wr_q;
      addr_q     <= addr_buf_q;
      wdata_q    <= data_buf_q;
      last_tag_q <= tag_q;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_q      <= '0;
    end else if (strobe_q) begin
      if (bus_ack) begin
        strobe_q <= 1'b0;
        ack_q    <= 1'b1;
        rdata_q  <= write_q ? '0 : bus_rdata;
      end else if (tmo_q == TMO_LAST) begin
        strobe_q  <= 1'b0;
        timeout_q <= 1'b1;
        rdata_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= '0;
      link_cnt_q <= '0;
      link_ok_q  <= 1'b0;
    end else begin
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      if (comma) begin
        link_cnt_q <= '0;
        link_ok_q  <= 1'b1;
      end else begin
        if (link_cnt_q != LINK_LIM) link_cnt_q <= link_cnt_q + 1'b1;
        if (!rx_valid || (link_cnt_q >= LINK_LIM - 1'b1)) link_ok_q <= 1'b0;
      end
    end
  end

  logic [3:0]    slot_q;
  logic [7:0]    tx_byte_q, snap_status_q, tx_next_byte;
  logic          tx_is_k_q, tx_next_k;
  logic [DW-1:0] snap_rdata_q;
`ifdef CTRL_LINK_CRC_EN
  logic [7:0]    tx_crc_q;
`endif

  always_comb begin
    tx_next_byte = K_COMMA;
    tx_next_k    = 1'b1;
    if (slot_q == 4'd1) begin
      tx_next_byte = snap_status_q;
      tx_next_k    = 1'b0;
`ifdef CTRL_LINK_CRC_EN
    end else if (slot_q == TX_LAST) begin
      tx_next_byte = tx_crc_q;
      tx_next_k    = 1'b0;
`endif
    end else if (slot_q != 4'd0) begin
      tx_next_byte = snap_rdata_q[8*(int'(slot_q) - 2) +: 8];
      tx_next_k    = 1'b0;
    end
  end

  // Status and rdata are frozen at the comma slot so one frame never mixes two transactions.
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q        <= '0;
      tx_byte_q     <= K_COMMA;
      tx_is_k_q     <= 1'b1;
      snap_status_q <= '0;
      snap_rdata_q  <= '0;
`ifdef CTRL_LINK_CRC_EN
      tx_crc_q      <= '0;
`endif
    end else begin
      tx_byte_q <= tx_next_byte;
      tx_is_k_q <= tx_next_k;
      slot_q    <= (slot_q == TX_LAST) ? 4'd0 : slot_q + 4'd1;
      if (slot_q == 4'd0) begin
        snap_status_q <= {last_tag_q, 1'b0, strobe_q, timeout_q, ack_q};
        snap_rdata_q  <= rdata_q;
      end
`ifdef CTRL_LINK_CRC_EN
      if (slot_q == 4'd1) tx_crc_q <= crc8(8'h00, tx_next_byte);
      else if (slot_q >= 4'd2 && slot_q < TX_LAST) tx_crc_q <= crc8(tx_crc_q, tx_next_byte);
`endif
    end
  end

  assign tx_byte       = tx_byte_q;
  assign tx_is_k       = tx_is_k_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_write     = write_q;
  assign bus_strobe    = strobe_q;
  assign link_ok       = link_ok_q;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_ctrl_link_slave_param.sv
// Scoreboard bench for ctrl_link_slave_param: expected bus transactions and response frames are queued by
// the stimulus and consumed by independent bus and TX monitors.
module tb_ctrl_link_slave_param;
  localparam int AB = 2;
  localparam int DB = 4;
  localparam int BT = 10;
  localparam int LT = 64;
`ifdef CTRL_LINK_CRC_EN
  localparam int RB = DB + 2;
`else
  localparam int RB = DB + 1;
`endif

  logic            byte_clk, reset_n;
  logic [7:0]      rx_byte, tx_byte, frame_err_cnt;
  logic            rx_is_k, rx_valid, tx_is_k;
  logic [8*AB-1:0] bus_addr;
  logic [8*DB-1:0] bus_wdata, bus_rdata;
  logic            bus_write, bus_strobe, bus_ack, link_ok;

  ctrl_link_slave_param #(
    .ADDR_BYTES(AB), .DATA_BYTES(DB), .BUS_TIMEOUT(BT), .LINK_TIMEOUT(LT)
  ) dut (
    .byte_clk(byte_clk), .reset_n(reset_n),
    .rx_byte(rx_byte), .rx_is_k(rx_is_k), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_is_k(tx_is_k),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_strobe(bus_strobe), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .link_ok(link_ok), .frame_err_cnt(frame_err_cnt)
  );

  initial byte_clk = 1'b0;
  always #5 byte_clk = ~byte_clk;

  typedef struct {
    logic [8*AB-1:0] addr;
    logic [8*DB-1:0] wdata;
    logic            wr;
    int              len;
  } bus_t;

  typedef struct {
    logic [7:0]      status;
    logic [8*DB-1:0] rdata;
    logic            chk_data;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    ack_delay = 0;
  logic [8*DB-1:0] rd_val = '0;

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic k);
    rx_byte  = b;
    rx_is_k  = k;
    rx_valid = 1'b1;
    @(negedge byte_clk);
  endtask

  task automatic send_frame(input logic [7:0] ctrl, input logic [8*AB-1:0] addr, input logic [8*DB-1:0] data);
    logic [7:0] crc;
    crc = crc8(8'h00, ctrl);
    send_byte(ctrl, 1'b0);
    for (int i = 0; i < AB; i++) begin
      send_byte(addr[8*i +: 8], 1'b0);
      crc = crc8(crc, addr[8*i +: 8]);
    end
    for (int i = 0; i < DB; i++) begin
      send_byte(data[8*i +: 8], 1'b0);
      crc = crc8(crc, data[8*i +: 8]);
    end
`ifdef CTRL_LINK_CRC_EN
    send_byte(crc, 1'b0);
`endif
    send_byte(8'hBC, 1'b1);
    $display("frame ctrl=%02h addr=%0h data=%0h sent, err_cnt=%0d", ctrl, addr, data, frame_err_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_frame(8'h00, '0, '0);
  endtask

  // Bus responder: acks on the ack_delay-th cycle of a strobe (0 = never acks).
  int resp_hi;
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    resp_hi   = 0;
    forever begin
      @(negedge byte_clk);
      if (bus_strobe) begin
        resp_hi++;
        if (ack_delay > 0 && resp_hi == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_val;
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        resp_hi = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Bus monitor: pops one expected transaction per strobe pulse and checks stability and pulse length.
  bus_t bm_cur;
  logic bm_prev = 1'b0;
  logic bm_active = 1'b0;
  int   bm_hi = 0;
  initial begin
    forever begin
      @(negedge byte_clk);
      if (bus_strobe && !bm_prev) begin
        if (exp_bus.size() == 0) begin
          check("unexpected_strobe", 64'(1), 64'(0));
        end else begin
          bm_cur    = exp_bus.pop_front();
          bm_active = 1'b1;
          bm_hi     = 0;
          $display("bus strobe addr=%0h wdata=%0h write=%0b", bus_addr, bus_wdata, bus_write);
        end
      end
      if (bus_strobe && bm_active) begin
        bm_hi++;
        check("bus_addr", 64'(bus_addr), 64'(bm_cur.addr));
        check("bus_wdata", 64'(bus_wdata), 64'(bm_cur.wdata));
        check("bus_write", 64'(bus_write), 64'(bm_cur.wr));
      end
      if (!bus_strobe && bm_prev && bm_active) begin
        if (bm_cur.len != 0) check("strobe_len", 64'(bm_hi), 64'(bm_cur.len));
        bm_active = 1'b0;
      end
      bm_prev = bus_strobe;
    end
  end

  // TX monitor: the first idle-status frame carrying the expected tag is compared against the queue head.
  logic [7:0]      fb [RB];
  int              fidx = 0;
  logic            in_f = 1'b0;
  resp_t           rm;
  logic [8*DB-1:0] rm_data;
  logic [7:0]      rm_crc;
  initial begin
    forever begin
      @(negedge byte_clk);
      if (tx_is_k && tx_byte == 8'hBC) begin
        fidx = 0;
        in_f = 1'b1;
      end else if (in_f) begin
        fb[fidx] = tx_byte;
        fidx++;
        if (fidx == RB) begin
          in_f = 1'b0;
          if (exp_resp.size() > 0 && fb[0][7:4] == exp_resp[0].status[7:4] && !fb[0][2]) begin
            rm = exp_resp.pop_front();
            for (int i = 0; i < DB; i++) rm_data[8*i +: 8] = fb[1+i];
            $display("response status=%02h rdata=%0h", fb[0], rm_data);
            check("resp_status", 64'(fb[0]), 64'(rm.status));
            if (rm.chk_data) check("resp_rdata", 64'(rm_data), 64'(rm.rdata));
            rm_crc = 8'h00;
            for (int i = 0; i <= DB; i++) rm_crc = crc8(rm_crc, fb[i]);
`ifdef CTRL_LINK_CRC_EN
            check("resp_crc", 64'(fb[RB-1]), 64'(rm_crc));
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rx_is_k  = 1'b0;
    repeat (3) @(negedge byte_clk);
    check("rst_tx_byte", 64'(tx_byte), 64'(8'hBC));
    check("rst_tx_is_k", 64'(tx_is_k), 64'(1));
    check("rst_strobe", 64'(bus_strobe), 64'(0));
    check("rst_link_ok", 64'(link_ok), 64'(0));
    check("rst_err_cnt", 64'(frame_err_cnt), 64'(0));
    reset_n = 1'b1;
    @(negedge byte_clk);
    send_byte(8'hBC, 1'b1);
    check("link_up", 64'(link_ok), 64'(1));

    // Write, retransmitted five times: one strobe, status tag 1 + ack.
    ack_delay = 3;
    exp_bus.push_back('{addr: 16'h1234, wdata: 32'h12345678, wr: 1'b1, len: 3});
    exp_resp.push_back('{status: 8'h11, rdata: '0, chk_data: 1'b0});
    repeat (5) send_frame(8'h13, 16'h1234, 32'h12345678);
    idle(2);
    check("dedup_err_cnt", 64'(frame_err_cnt), 64'(0));

    // Read with ack after 2 cycles.
    ack_delay = 2;
    rd_val    = 32'hCAFEF00D;
    exp_bus.push_back('{addr: 16'h0040, wdata: 32'h0, wr: 1'b0, len: 2});
    exp_resp.push_back('{status: 8'h21, rdata: 32'hCAFEF00D, chk_data: 1'b1});
    send_frame(8'h21, 16'h0040, 32'h0);
    idle(3);

    // Read never acked: strobe held exactly BUS_TIMEOUT cycles.
    ack_delay = 0;
    exp_bus.push_back('{addr: 16'h0077, wdata: 32'h0, wr: 1'b0, len: BT});
    exp_resp.push_back('{status: 8'h32, rdata: 32'h0, chk_data: 1'b1});
    send_frame(8'h31, 16'h0077, 32'h0);
    idle(4);

    // Short frame, then a K28.7 mid-frame.
    send_byte(8'h51, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hBC, 1'b1);
    check("short_frame_err", 64'(frame_err_cnt), 64'(1));
    send_byte(8'h51, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFC, 1'b1);
    check("k_char_err", 64'(frame_err_cnt), 64'(2));
    check("no_strobe_on_err", 64'(bus_strobe), 64'(0));
    send_byte(8'hBC, 1'b1);
    idle(1);

    // Link timeout and recovery.
    repeat (LT - 1) send_byte(8'h00, 1'b0);
    check("link_before_timeout", 64'(link_ok), 64'(1));
    repeat (2) send_byte(8'h00, 1'b0);
    check("link_timeout", 64'(link_ok), 64'(0));
    send_byte(8'hBC, 1'b1);
    check("link_recover", 64'(link_ok), 64'(1));
    rx_valid = 1'b0;
    @(negedge byte_clk);
    check("link_rx_invalid", 64'(link_ok), 64'(0));
    send_byte(8'hBC, 1'b1);
    check("link_recover2", 64'(link_ok), 64'(1));

    // Reset asserted while strobe is high.
    ack_delay = 0;
    exp_bus.push_back('{addr: 16'h0ABC, wdata: 32'hA5A55A5A, wr: 1'b1, len: 0});
    send_frame(8'h43, 16'h0ABC, 32'hA5A55A5A);
    check("strobe_after_commit", 64'(bus_strobe), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_strobe", 64'(bus_strobe), 64'(0));
    check("async_rst_tx_byte", 64'(tx_byte), 64'(8'hBC));
    check("async_rst_tx_is_k", 64'(tx_is_k), 64'(1));
    check("async_rst_err_cnt", 64'(frame_err_cnt), 64'(0));
    rx_valid = 1'b0;
    repeat (2) @(negedge byte_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge byte_clk);

    check("bus_queue_empty", 64'(exp_bus.size()), 64'(0));
    check("resp_queue_empty", 64'(exp_resp.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
